modport_slave: RTL and testbench

- AXI3-style slave with a single clock and internal 64-bit-wide memory; it serves as the memory-side target of the DMA controller's AXI port 0.
- The block accepts write bursts on the AW/W channels, returns responses on the B channel, and returns read bursts on the AR/R channels.
- It holds at most one write burst and one read burst at a time; the read and write paths run independently and concurrently.

---
 rtl/modport_slave_pkg.sv | 23 ++
 rtl/modport_slave_if.sv | 48 ++++
 rtl/modport_slave_mem.sv | 26 ++
 rtl/modport_slave.sv | 182 ++++++++++++++++++
 tb/tb_modport_slave.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/modport_slave_pkg.sv
// Shared constants and FSM state types for the modport_slave AXI3 memory target.
package modport_slave_pkg;

  localparam int DEF_ID_BITS   = 4;
  localparam int DEF_LEN_BITS  = 4;
  localparam int DEF_SIZE_BITS = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

endpackage

// File: rtl/modport_slave_if.sv
// AXI3 port-0 bundle between the DMA master and the modport_slave memory target.
interface modport_slave_if #(
  parameter int ID_BITS   = modport_slave_pkg::DEF_ID_BITS,
  parameter int LEN_BITS  = modport_slave_pkg::DEF_LEN_BITS,
  parameter int SIZE_BITS = modport_slave_pkg::DEF_SIZE_BITS
);
  logic [ID_BITS-1:0]   AWID0;
  logic [31:0]          AWADDR0;
  logic [LEN_BITS-1:0]  AWLEN0;
  logic [SIZE_BITS-1:0] AWSIZE0;
  logic                 AWVALID0, AWREADY0;

  logic [ID_BITS-1:0]   WID0;
  logic [63:0]          WDATA0;
  logic [7:0]           WSTRB0;
  logic                 WLAST0, WVALID0, WREADY0;

  logic [ID_BITS-1:0]   BID0;
  logic [1:0]           BRESP0;
  logic                 BVALID0, BREADY0;

  logic [ID_BITS-1:0]   ARID0;
  logic [31:0]          ARADDR0;
  logic [LEN_BITS-1:0]  ARLEN0;
  logic [SIZE_BITS-1:0] ARSIZE0;
  logic                 ARVALID0, ARREADY0;

  logic [ID_BITS-1:0]   RID0;
  logic [63:0]          RDATA0;
  logic [1:0]           RRESP0;
  logic                 RLAST0, RVALID0, RREADY0;

  modport master (
    output AWID0, AWADDR0, AWLEN0, AWSIZE0, AWVALID0, input AWREADY0,
    output WID0, WDATA0, WSTRB0, WLAST0, WVALID0, input WREADY0,
    input  BID0, BRESP0, BVALID0, output BREADY0,
    output ARID0, ARADDR0, ARLEN0, ARSIZE0, ARVALID0, input ARREADY0,
    input  RID0, RDATA0, RRESP0, RLAST0, RVALID0, output RREADY0
  );

  modport slave (
    input  AWID0, AWADDR0, AWLEN0, AWSIZE0, AWVALID0, output AWREADY0,
    input  WID0, WDATA0, WSTRB0, WLAST0, WVALID0, output WREADY0,
    output BID0, BRESP0, BVALID0, input BREADY0,
    input  ARID0, ARADDR0, ARLEN0, ARSIZE0, ARVALID0, output ARREADY0,
    output RID0, RDATA0, RRESP0, RLAST0, RVALID0, input RREADY0
  );
endinterface

// File: rtl/modport_slave_mem.sv
// 64-bit dual-port word memory: byte-strobed synchronous write, asynchronous read.
// Read is combinational so a same-edge write is seen by the caller's register as old data.
module modport_slave_mem #(
  parameter  int WORDS = 256,
  localparam int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic [7:0]    wstrb,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);
  logic [63:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/modport_slave.sv
// AXI3 slave with internal 64-bit memory; independent single-burst write and read FSMs.
// Define AXI_SLV_DECERR_EN to answer bursts starting beyond the memory with DECERR.
module modport_slave
  import modport_slave_pkg::*;
#(
  parameter int ID_BITS   = DEF_ID_BITS,
  parameter int LEN_BITS  = DEF_LEN_BITS,
  parameter int SIZE_BITS = DEF_SIZE_BITS,
  parameter int MEM_WORDS = 256
) (
  input logic           clk,
  input logic           reset,
  modport_slave_if.slave bus
);
  localparam int AW = $clog2(MEM_WORDS);

  w_state_e             w_state;
  logic [ID_BITS-1:0]   w_id;
  logic [31:0]          w_addr;
  logic [LEN_BITS-1:0]  w_len, w_cnt;
  logic [SIZE_BITS-1:0] w_size;
  logic                 w_err, w_dec;

  r_state_e             r_state;
  logic [ID_BITS-1:0]   r_id;
  logic [31:0]          r_addr;
  logic [LEN_BITS-1:0]  r_len, r_cnt;
  logic [SIZE_BITS-1:0] r_size;
  logic                 r_dec;

  logic aw_dec, ar_dec;
`ifdef AXI_SLV_DECERR_EN
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd8;
  assign aw_dec = {1'b0, bus.AWADDR0} >= MEM_BYTES;
  assign ar_dec = {1'b0, bus.ARADDR0} >= MEM_BYTES;
`else
  assign aw_dec = 1'b0;
  assign ar_dec = 1'b0;
`endif

  logic        w_fire, w_last_beat, w_err_nxt, mem_we;
  logic        r_fire;
  logic [63:0] mem_rdata, r_beat_data;
  logic [1:0]  r_beat_resp;

  assign w_fire      = bus.WVALID0 && bus.WREADY0;
  assign w_last_beat = (w_cnt == w_len);
  // The error covers the beat being accepted now, so the response sees it too.
  assign w_err_nxt   = w_err || (bus.WID0 != w_id) || (bus.WLAST0 != w_last_beat);
  assign mem_we      = w_fire && !w_dec;

  assign r_fire      = bus.RVALID0 && bus.RREADY0;
  assign r_beat_data = r_dec ? 64'd0 : mem_rdata;
  assign r_beat_resp = r_dec ? RESP_DECERR : RESP_OKAY;

  modport_slave_mem #(.WORDS(MEM_WORDS)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (w_addr[3 +: AW]),
    .wdata (bus.WDATA0),
    .wstrb (bus.WSTRB0),
    .raddr (r_addr[3 +: AW]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state      <= W_IDLE;
      w_id         <= '0;
      w_addr       <= '0;
      w_len        <= '0;
      w_cnt        <= '0;
      w_size       <= '0;
      w_err        <= 1'b0;
      w_dec        <= 1'b0;
      bus.AWREADY0 <= 1'b0;
      bus.WREADY0  <= 1'b0;
      bus.BVALID0  <= 1'b0;
      bus.BID0     <= '0;
      bus.BRESP0   <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          bus.AWREADY0 <= 1'b1;
          if (bus.AWVALID0 && bus.AWREADY0) begin
            w_id         <= bus.AWID0;
            w_addr       <= bus.AWADDR0;
            w_len        <= bus.AWLEN0;
            w_size       <= bus.AWSIZE0;
            w_cnt        <= '0;
            w_err        <= 1'b0;
            w_dec        <= aw_dec;
            bus.AWREADY0 <= 1'b0;
            bus.WREADY0  <= 1'b1;
            w_state      <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_addr <= w_addr + (32'd1 << w_size);
            w_cnt  <= w_cnt + LEN_BITS'(1);
            w_err  <= w_err_nxt;
            if (w_last_beat) begin
              bus.WREADY0 <= 1'b0;
              bus.BVALID0 <= 1'b1;
              bus.BID0    <= w_id;
              bus.BRESP0  <= w_dec ? RESP_DECERR : (w_err_nxt ? RESP_SLVERR : RESP_OKAY);
              w_state     <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bus.BVALID0 && bus.BREADY0) begin
            bus.BVALID0  <= 1'b0;
            bus.AWREADY0 <= 1'b1;
            w_state      <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // r_addr always points at the next beat to load, so the memory read port needs no mux.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= R_IDLE;
      r_id         <= '0;
      r_addr       <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_size       <= '0;
      r_dec        <= 1'b0;
      bus.ARREADY0 <= 1'b0;
      bus.RVALID0  <= 1'b0;
      bus.RID0     <= '0;
      bus.RDATA0   <= '0;
      bus.RRESP0   <= '0;
      bus.RLAST0   <= 1'b0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          bus.ARREADY0 <= 1'b1;
          if (bus.ARVALID0 && bus.ARREADY0) begin
            r_id         <= bus.ARID0;
            r_addr       <= bus.ARADDR0;
            r_len        <= bus.ARLEN0;
            r_size       <= bus.ARSIZE0;
            r_cnt        <= '0;
            r_dec        <= ar_dec;
            bus.ARREADY0 <= 1'b0;
            r_state      <= R_DATA;
          end
        end
        R_DATA: begin
          if (!bus.RVALID0) begin
            bus.RVALID0 <= 1'b1;
            bus.RID0    <= r_id;
            bus.RDATA0  <= r_beat_data;
            bus.RRESP0  <= r_beat_resp;
            bus.RLAST0  <= (r_len == '0);
            r_addr      <= r_addr + (32'd1 << r_size);
          end else if (r_fire) begin
            if (bus.RLAST0) begin
              bus.RVALID0  <= 1'b0;
              bus.RLAST0   <= 1'b0;
              bus.ARREADY0 <= 1'b1;
              r_state      <= R_IDLE;
            end else begin
              bus.RDATA0 <= r_beat_data;
              bus.RRESP0 <= r_beat_resp;
              bus.RLAST0 <= ((r_cnt + LEN_BITS'(1)) == r_len);
              r_cnt      <= r_cnt + LEN_BITS'(1);
              r_addr     <= r_addr + (32'd1 << r_size);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_modport_slave.sv
// Directed bench for modport_slave: bursts, strobes, backpressure, errors, wrap, reset.
module tb_modport_slave;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;

  modport_slave_if #(.ID_BITS(4), .LEN_BITS(4), .SIZE_BITS(2)) bus ();

  modport_slave #(.ID_BITS(4), .LEN_BITS(4), .SIZE_BITS(2), .MEM_WORDS(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] size);
    int n = 0;
    bus.AWID0 = id; bus.AWADDR0 = addr; bus.AWLEN0 = len; bus.AWSIZE0 = size;
    bus.AWVALID0 = 1'b1;
    while (bus.AWREADY0 !== 1'b1 && n < 50) begin tick(); n++; end
    chk("awready", 64'(bus.AWREADY0), 64'd1);
    tick();
    bus.AWVALID0 = 1'b0;
  endtask

  task automatic send_w(input logic [3:0] id, input logic [63:0] data, input logic [7:0] strb,
                        input logic last);
    int n = 0;
    bus.WID0 = id; bus.WDATA0 = data; bus.WSTRB0 = strb; bus.WLAST0 = last;
    bus.WVALID0 = 1'b1;
    while (bus.WREADY0 !== 1'b1 && n < 50) begin tick(); n++; end
    chk("wready", 64'(bus.WREADY0), 64'd1);
    tick();
    bus.WVALID0 = 1'b0;
  endtask

  task automatic get_b(input logic [3:0] id, input logic [1:0] resp, input int stall);
    int n = 0;
    while (bus.BVALID0 !== 1'b1 && n < 50) begin tick(); n++; end
    chk("bvalid", 64'(bus.BVALID0), 64'd1);
    chk("bid", 64'(bus.BID0), 64'(id));
    chk("bresp", 64'(bus.BRESP0), 64'(resp));
    repeat (stall) begin
      tick();
      chk("bvalid_hold", 64'(bus.BVALID0), 64'd1);
      chk("bid_hold", 64'(bus.BID0), 64'(id));
      chk("bresp_hold", 64'(bus.BRESP0), 64'(resp));
    end
    bus.BREADY0 = 1'b1;
    tick();
    bus.BREADY0 = 1'b0;
    chk("bvalid_drop", 64'(bus.BVALID0), 64'd0);
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] size);
    int n = 0;
    bus.ARID0 = id; bus.ARADDR0 = addr; bus.ARLEN0 = len; bus.ARSIZE0 = size;
    bus.ARVALID0 = 1'b1;
    while (bus.ARREADY0 !== 1'b1 && n < 50) begin tick(); n++; end
    chk("arready", 64'(bus.ARREADY0), 64'd1);
    tick();
    bus.ARVALID0 = 1'b0;
  endtask

  task automatic get_r(input logic [63:0] data, input logic [3:0] id, input logic [1:0] resp,
                       input logic last, input int stall);
    int n = 0;
    while (bus.RVALID0 !== 1'b1 && n < 50) begin tick(); n++; end
    chk("rvalid", 64'(bus.RVALID0), 64'd1);
    chk("rdata", bus.RDATA0, data);
    chk("rid", 64'(bus.RID0), 64'(id));
    chk("rresp", 64'(bus.RRESP0), 64'(resp));
    chk("rlast", 64'(bus.RLAST0), 64'(last));
    repeat (stall) begin
      tick();
      chk("rvalid_hold", 64'(bus.RVALID0), 64'd1);
      chk("rdata_hold", bus.RDATA0, data);
      chk("rid_hold", 64'(bus.RID0), 64'(id));
    end
    bus.RREADY0 = 1'b1;
    tick();
    bus.RREADY0 = 1'b0;
  endtask

  initial begin
    bus.AWVALID0 = 0; bus.AWID0 = 0; bus.AWADDR0 = 0; bus.AWLEN0 = 0; bus.AWSIZE0 = 0;
    bus.WVALID0 = 0; bus.WID0 = 0; bus.WDATA0 = 0; bus.WSTRB0 = 0; bus.WLAST0 = 0;
    bus.BREADY0 = 0; bus.RREADY0 = 0;
    bus.ARVALID0 = 0; bus.ARID0 = 0; bus.ARADDR0 = 0; bus.ARLEN0 = 0; bus.ARSIZE0 = 0;

    // Reset state
    repeat (2) tick();
    chk("rst_awready", 64'(bus.AWREADY0), 64'd0);
    chk("rst_arready", 64'(bus.ARREADY0), 64'd0);
    chk("rst_wready", 64'(bus.WREADY0), 64'd0);
    chk("rst_bvalid", 64'(bus.BVALID0), 64'd0);
    chk("rst_rvalid", 64'(bus.RVALID0), 64'd0);
    reset = 1'b1;
    tick();
    chk("rel_awready", 64'(bus.AWREADY0), 64'd1);
    chk("rel_arready", 64'(bus.ARREADY0), 64'd1);

    // Single write then read
    send_aw(4'd5, 32'h10, 4'd0, 2'd3);
    send_w(4'd5, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1);
    get_b(4'd5, 2'b00, 0);
    send_ar(4'd5, 32'h10, 4'd0, 2'd3);
    get_r(64'hDEADBEEF_CAFEF00D, 4'd5, 2'b00, 1'b1, 0);
    chk("r1_rvalid_end", 64'(bus.RVALID0), 64'd0);

    // Strobed 4-beat burst over a prefilled word, with B and R backpressure
    send_aw(4'd1, 32'h48, 4'd0, 2'd3);
    send_w(4'd1, 64'hAAAABBBB_CCCCDDDD, 8'hFF, 1'b1);
    get_b(4'd1, 2'b00, 0);
    send_aw(4'd2, 32'h40, 4'd3, 2'd3);
    send_w(4'd2, 64'd1, 8'hFF, 1'b0);
    send_w(4'd2, 64'd2, 8'h0F, 1'b0);
    send_w(4'd2, 64'd3, 8'hFF, 1'b0);
    send_w(4'd2, 64'd4, 8'hFF, 1'b1);
    get_b(4'd2, 2'b00, 2);
    send_ar(4'd3, 32'h40, 4'd3, 2'd3);
    get_r(64'd1, 4'd3, 2'b00, 1'b0, 0);
    get_r(64'hAAAABBBB_00000002, 4'd3, 2'b00, 1'b0, 3);
    get_r(64'd3, 4'd3, 2'b00, 1'b0, 0);
    get_r(64'd4, 4'd3, 2'b00, 1'b1, 0);
    chk("r4_rvalid_end", 64'(bus.RVALID0), 64'd0);

    // Protocol errors: early WLAST, then WID mismatch
    send_aw(4'd4, 32'h80, 4'd3, 2'd3);
    send_w(4'd4, 64'h10, 8'hFF, 1'b0);
    send_w(4'd4, 64'h11, 8'hFF, 1'b1);
    send_w(4'd4, 64'h12, 8'hFF, 1'b0);
    send_w(4'd4, 64'h13, 8'hFF, 1'b1);
    get_b(4'd4, 2'b10, 0);
    send_aw(4'd6, 32'h90, 4'd1, 2'd3);
    send_w(4'd14, 64'h20, 8'hFF, 1'b0);
    send_w(4'd6, 64'h21, 8'hFF, 1'b1);
    get_b(4'd6, 2'b10, 0);

    // Narrow 4-byte beats stay in the same 64-bit word
    send_aw(4'd8, 32'h100, 4'd1, 2'd2);
    send_w(4'd8, 64'h11, 8'hFF, 1'b0);
    send_w(4'd8, 64'h22, 8'hFF, 1'b1);
    get_b(4'd8, 2'b00, 0);
    send_ar(4'd8, 32'h100, 4'd1, 2'd2);
    get_r(64'h22, 4'd8, 2'b00, 1'b0, 0);
    get_r(64'h22, 4'd8, 2'b00, 1'b1, 0);

    // Burst crossing the top word wraps to word 0
    send_aw(4'd9, 32'h7F8, 4'd1, 2'd3);
    send_w(4'd9, 64'h1111_1111_1111_1111, 8'hFF, 1'b0);
    send_w(4'd9, 64'h2222_2222_2222_2222, 8'hFF, 1'b1);
    get_b(4'd9, 2'b00, 0);
    send_ar(4'd10, 32'h7F8, 4'd1, 2'd3);
    get_r(64'h1111_1111_1111_1111, 4'd10, 2'b00, 1'b0, 0);
    get_r(64'h2222_2222_2222_2222, 4'd10, 2'b00, 1'b1, 0);
`ifdef AXI_SLV_DECERR_EN
    send_ar(4'd11, 32'h1000, 4'd1, 2'd3);
    get_r(64'd0, 4'd11, 2'b11, 1'b0, 0);
    get_r(64'd0, 4'd11, 2'b11, 1'b1, 0);
    send_aw(4'd12, 32'h1000, 4'd0, 2'd3);
    send_w(4'd12, 64'h99, 8'hFF, 1'b1);
    get_b(4'd12, 2'b11, 0);
    send_ar(4'd12, 32'h0, 4'd0, 2'd3);
    get_r(64'h2222_2222_2222_2222, 4'd12, 2'b00, 1'b1, 0);
`else
    send_ar(4'd11, 32'h1000, 4'd0, 2'd3);
    get_r(64'h2222_2222_2222_2222, 4'd11, 2'b00, 1'b1, 0);
`endif

    // Concurrent write and read bursts to different words
    fork
      begin
        send_aw(4'd7, 32'h200, 4'd1, 2'd3);
        send_w(4'd7, 64'h5555_0000_0000_0055, 8'hFF, 1'b0);
        send_w(4'd7, 64'h6666_0000_0000_0066, 8'hFF, 1'b1);
        get_b(4'd7, 2'b00, 0);
      end
      begin
        send_ar(4'd9, 32'h40, 4'd1, 2'd3);
        get_r(64'd1, 4'd9, 2'b00, 1'b0, 0);
        get_r(64'hAAAABBBB_00000002, 4'd9, 2'b00, 1'b1, 0);
      end
    join
    send_ar(4'd2, 32'h200, 4'd1, 2'd3);
    get_r(64'h5555_0000_0000_0055, 4'd2, 2'b00, 1'b0, 0);
    get_r(64'h6666_0000_0000_0066, 4'd2, 2'b00, 1'b1, 0);

    // Reset mid-burst aborts both paths; the accepted beat stays in memory
    send_aw(4'd3, 32'h300, 4'd3, 2'd3);
    send_w(4'd3, 64'h77, 8'hFF, 1'b0);
    send_ar(4'd4, 32'h40, 4'd3, 2'd3);
    tick();
    chk("mid_rvalid_pre", 64'(bus.RVALID0), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_awready", 64'(bus.AWREADY0), 64'd0);
    chk("mid_wready", 64'(bus.WREADY0), 64'd0);
    chk("mid_bvalid", 64'(bus.BVALID0), 64'd0);
    chk("mid_arready", 64'(bus.ARREADY0), 64'd0);
    chk("mid_rvalid", 64'(bus.RVALID0), 64'd0);
    chk("mid_rdata", bus.RDATA0, 64'd0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("mid_rel_awready", 64'(bus.AWREADY0), 64'd1);
    chk("mid_rel_arready", 64'(bus.ARREADY0), 64'd1);
    chk("mid_rel_wready", 64'(bus.WREADY0), 64'd0);
    send_ar(4'd1, 32'h300, 4'd0, 2'd3);
    get_r(64'h77, 4'd1, 2'b00, 1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
